// File: rtl/burst_ram_cache.sv
// Direct-mapped write-back data cache between a 32-bit core port and a BurstRAM
// command/burst interface. One cache line is exactly one RAM burst.
module burst_ram_cache #(
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4,
    parameter int unsigned CACHE_LINE_IX_BITWIDTH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [31:0]                   address,
    input  logic [3:0]                    write_enable,
    input  logic [31:0]                   data_in,
    output logic [31:0]                   data_out,
    output logic                          data_out_ready,
    output logic                          busy,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                   br_wr_data,
    output logic [7:0]                    br_data_mask,
    input  logic [63:0]                   br_rd_data,
    input  logic                          br_rd_data_valid,
    input  logic                          br_busy
);

    localparam int unsigned BW     = RAM_BURST_DATA_BITWIDTH;
    localparam int unsigned OFF    = $clog2(RAM_BURST_DATA_COUNT * 8);
    localparam int unsigned BEAT_W = OFF - 3;
    localparam int unsigned IX     = CACHE_LINE_IX_BITWIDTH;
    localparam int unsigned LINES  = 1 << IX;
    localparam int unsigned TAG_W  = RAM_DEPTH_BITWIDTH + 3 - OFF - IX;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [2:0] {StIdle, StWbCmd, StWbData, StRdCmd, StRdWait} state_e;

    state_e state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IX-1:0]     req_idx_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [BW-1:0]     line_q [LINES][RAM_BURST_DATA_COUNT];
    logic              ready_q;
    logic [31:0]       rdata_q;

    logic [IX-1:0]     cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [BEAT_W-1:0] cur_beat;
    logic              cur_half;
    logic              req, hit;
    logic [BW-1:0]     hit_beat, merged;
    logic              start_miss, fill_beat, fill_done;
    logic [RAM_DEPTH_BITWIDTH-1:0] victim_addr, fill_addr;
    logic              unused_addr;

    assign cur_idx  = address[OFF+IX-1:OFF];
    assign cur_tag  = address[RAM_DEPTH_BITWIDTH+2:OFF+IX];
    assign cur_beat = address[OFF-1:3];
    assign cur_half = address[2];
    assign unused_addr = ^{address[31:RAM_DEPTH_BITWIDTH+3], address[1:0]};

    // The cycle after a completion the core still holds the old request, so skip it.
    assign req = (state_q == StIdle) && enable && !ready_q;
    assign hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    assign victim_addr = {tag_q[req_idx_q], req_idx_q, {BEAT_W{1'b0}}};
    assign fill_addr   = {req_tag_q, req_idx_q, {BEAT_W{1'b0}}};

    assign data_out       = rdata_q;
    assign data_out_ready = ready_q;
    assign busy           = (state_q != StIdle);
    assign br_data_mask   = 8'h00;

    // Select the addressed beat and merge strobed write bytes into its 32-bit half.
    always_comb begin
        hit_beat = line_q[cur_idx][cur_beat];
        merged   = hit_beat;
        for (int b = 0; b < 4; b++) begin
            if (write_enable[b]) begin
                merged[(cur_half ? 32 : 0) + b*8 +: 8] = data_in[b*8 +: 8];
            end
        end
    end

    // Miss-handling FSM: next state, beat counter and BurstRAM command outputs.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        br_cmd     = 1'b0;
        br_cmd_en  = 1'b0;
        br_addr    = '0;
        br_wr_data = '0;
        start_miss = 1'b0;
        fill_beat  = 1'b0;
        fill_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    start_miss = 1'b1;
                    beat_d     = '0;
                    state_d    = (valid_q[cur_idx] && dirty_q[cur_idx]) ? StWbCmd : StRdCmd;
                end
            end
            StWbCmd: begin
                br_cmd     = 1'b1;
                br_addr    = victim_addr;
                br_wr_data = line_q[req_idx_q][0];
                if (!br_busy) begin
                    br_cmd_en = 1'b1;
                    beat_d    = BEAT_W'(1);
                    state_d   = StWbData;
                end
            end
            StWbData: begin
                br_cmd     = 1'b1;
                br_addr    = victim_addr;
                br_wr_data = line_q[req_idx_q][beat_q];
                beat_d     = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = StRdCmd;
                end
            end
            StRdCmd: begin
                br_addr = fill_addr;
                if (!br_busy) begin
                    br_cmd_en = 1'b1;
                    beat_d    = '0;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                br_addr = fill_addr;
                if (br_rd_data_valid) begin
                    fill_beat = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        fill_done = 1'b1;
                        beat_d    = '0;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, line metadata and core-side response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            req_idx_q <= '0;
            req_tag_q <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < int'(LINES); i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ready_q <= 1'b0;
            if (req && hit) begin
                ready_q <= 1'b1;
                if (write_enable == 4'b0000) begin
                    rdata_q <= cur_half ? hit_beat[63:32] : hit_beat[31:0];
                end else begin
                    dirty_q[cur_idx] <= 1'b1;
                end
            end
            if (start_miss) begin
                req_idx_q <= cur_idx;
                req_tag_q <= cur_tag;
            end
            if (fill_done) begin
                valid_q[req_idx_q] <= 1'b1;
                dirty_q[req_idx_q] <= 1'b0;
                tag_q[req_idx_q]   <= req_tag_q;
            end
        end
    end

    // Line storage: write-hit merges and refill beats; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && req && hit && (write_enable != 4'b0000)) begin
            line_q[cur_idx][cur_beat] <= merged;
        end
        if (!rst && fill_beat) begin
            line_q[req_idx_q][beat_q] <= br_rd_data;
        end
    end

endmodule
